// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan decoder.
//   SEG_0..SEG_F : active-low segment codes {g,f,e,d,c,b,a} for hex digits
//   state_t      : frame-assembly FSM states (HUNT, COLLECT, COMMIT)
//   seg_decode   : maps a 7-bit segment pattern to {ok, nibble}; ok=0 for
//                  any pattern that is not one of the sixteen hex glyphs
package seg7_pkg;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   function automatic logic [4:0] seg_decode(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         SEG_0:   res = {1'b1, 4'h0};
         SEG_1:   res = {1'b1, 4'h1};
         SEG_2:   res = {1'b1, 4'h2};
         SEG_3:   res = {1'b1, 4'h3};
         SEG_4:   res = {1'b1, 4'h4};
         SEG_5:   res = {1'b1, 4'h5};
         SEG_6:   res = {1'b1, 4'h6};
         SEG_7:   res = {1'b1, 4'h7};
         SEG_8:   res = {1'b1, 4'h8};
         SEG_9:   res = {1'b1, 4'h9};
         SEG_A:   res = {1'b1, 4'hA};
         SEG_B:   res = {1'b1, 4'hB};
         SEG_C:   res = {1'b1, 4'hC};
         SEG_D:   res = {1'b1, 4'hD};
         SEG_E:   res = {1'b1, 4'hE};
         SEG_F:   res = {1'b1, 4'hF};
         default: res = 5'h00;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seg7_settle.sv
// Input conditioning for the display port: registers the raw anode/cathode
// lines, counts how long the registered sample has been unchanged and emits
// a single-cycle digit event once a one-hot-low anode pattern has held for
// STABLE_CYCLES consecutive samples.
//   clock, reset : system clock, asynchronous active-high reset
//   anode        : raw active-low digit enables
//   cathode      : raw active-low segments {g,f,e,d,c,b,a}
//   digit_evt    : one-cycle pulse, at most once per dwell
//   digit_idx    : index of the enabled digit (valid with digit_evt)
//   pattern      : settled cathode pattern (valid with digit_evt)
module seg7_settle import seg7_pkg::*; #(
   parameter int STABLE_CYCLES = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] anode,
   input  logic [6:0] cathode,
   output logic       digit_evt,
   output logic [1:0] digit_idx,
   output logic [6:0] pattern
);

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   logic [3:0] anode_q;
   logic [6:0] cathode_q;
   logic [7:0] cnt_q, cnt_d;
   logic       evt_q, evt_d;
   logic [1:0] idx_q, idx_dec;
   logic [6:0] pat_q;
   logic       onehot;

   always_comb begin
      onehot  = 1'b1;
      idx_dec = 2'd0;
      case (anode_q)
         4'b1110: idx_dec = 2'd0;
         4'b1101: idx_dec = 2'd1;
         4'b1011: idx_dec = 2'd2;
         4'b0111: idx_dec = 2'd3;
         default: onehot  = 1'b0;
      endcase
   end

   // cnt_q is the number of consecutive samples equal to {anode_q,cathode_q}.
   // A new sample that differs restarts the run at 1.
   always_comb begin
      if ({anode, cathode} != {anode_q, cathode_q}) begin
         cnt_d = 8'd1;
      end else if (cnt_q < STABLE) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
      // Fire only on the transition into saturation so a long dwell yields
      // exactly one event.
      evt_d = onehot && (cnt_d == STABLE) && (cnt_q != STABLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         anode_q   <= 4'hF;
         cathode_q <= 7'h7F;
         cnt_q     <= 8'd0;
         evt_q     <= 1'b0;
         idx_q     <= 2'd0;
         pat_q     <= 7'h7F;
      end else begin
         anode_q   <= anode;
         cathode_q <= cathode;
         cnt_q     <= cnt_d;
         evt_q     <= evt_d;
         idx_q     <= idx_dec;
         pat_q     <= cathode_q;
      end
   end

   assign digit_evt = evt_q;
   assign digit_idx = idx_q;
   assign pattern   = pat_q;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Passive monitor for a multiplexed 4-digit seven-segment display. Settled
// digit captures are decoded to nibbles and assembled in digit order 0..3;
// each complete frame updates the 16-bit value.
//   clock, reset   : system clock, asynchronous active-high reset
//   anode[3:0]     : active-low digit enables, anode[0] = value[3:0]
//   cathode[6:0]   : active-low segments {g,f,e,d,c,b,a}
//   value[15:0]    : last complete frame
//   frame_valid    : one-cycle pulse when value is updated
//   value_changed  : pulse with frame_valid when the new frame differs
//   seg_err        : pulse on capture of an undecodable pattern
//   seq_err        : pulse on an out-of-order digit
//   stalled        : level, no digit event for TIMEOUT_CYCLES cycles
// Handshake: there is none; the block only observes. Every output pulse is
// a registered one-cycle strobe and value is stable whenever frame_valid is.
module seg7_scan_decoder import seg7_pkg::*; #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  anode,
   input  logic [6:0]  cathode,
   output logic [15:0] value,
   output logic        frame_valid,
   output logic        value_changed,
   output logic        seg_err,
   output logic        seq_err,
   output logic        stalled
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

   logic       digit_evt;
   logic [1:0] digit_idx;
   logic [6:0] pattern;

   seg7_settle #(.STABLE_CYCLES(STABLE_CYCLES)) u_settle (
      .clock     (clock),
      .reset     (reset),
      .anode     (anode),
      .cathode   (cathode),
      .digit_evt (digit_evt),
      .digit_idx (digit_idx),
      .pattern   (pattern)
   );

   state_t        state_q, state_d;
   logic [1:0]    next_idx_q, next_idx_d;
   logic [15:0]   nib_q, nib_d;
   logic [15:0]   value_q, value_d;
   logic          fv_q, fv_d;
   logic          vc_q, vc_d;
   logic          se_q, se_d;
   logic          qe_q, qe_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          stalled_q;

   logic [4:0]    dec;
   logic          dec_ok;
   logic [3:0]    dec_nib;
   logic [1:0]    last_idx;
   logic [15:0]   frame;

   assign dec      = seg_decode(pattern);
   assign dec_ok   = dec[4];
   assign dec_nib  = dec[3:0];
   // In COLLECT the last stored digit is always the one before next_idx.
   assign last_idx = next_idx_q - 2'd1;
   assign frame    = {dec_nib, nib_q[11:0]};

   always_comb begin
      state_d    = state_q;
      next_idx_d = next_idx_q;
      nib_d      = nib_q;
      value_d    = value_q;
      fv_d       = 1'b0;
      vc_d       = 1'b0;
      se_d       = 1'b0;
      qe_d       = 1'b0;
      if (state_q == COMMIT) begin
         state_d = HUNT;
      end
      if (digit_evt) begin
         if (!dec_ok) begin
            // A bad glyph always wins over any sequence handling.
            se_d    = 1'b1;
            state_d = HUNT;
         end else if (state_q == COLLECT) begin
            if (digit_idx == next_idx_q) begin
               nib_d[{digit_idx, 2'b00} +: 4] = dec_nib;
               if (digit_idx == 2'd3) begin
                  value_d = frame;
                  fv_d    = 1'b1;
                  vc_d    = (frame != value_q);
                  state_d = COMMIT;
               end else begin
                  next_idx_d = next_idx_q + 2'd1;
               end
            end else if (digit_idx == last_idx) begin
               // Same digit shown again: nothing new to store.
               state_d = COLLECT;
            end else if (digit_idx == 2'd0) begin
               qe_d       = 1'b1;
               nib_d[3:0] = dec_nib;
               next_idx_d = 2'd1;
            end else begin
               qe_d    = 1'b1;
               state_d = HUNT;
            end
         end else if (digit_idx == 2'd0) begin
            // HUNT (or the trailing COMMIT cycle): digit 0 opens a frame.
            nib_d[3:0] = dec_nib;
            next_idx_d = 2'd1;
            state_d    = COLLECT;
         end
      end
   end

   always_comb begin
      if (digit_evt) begin
         tmo_d = '0;
      end else if (tmo_q == TMO) begin
         tmo_d = tmo_q;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= HUNT;
         next_idx_q <= 2'd0;
         nib_q      <= 16'h0000;
         value_q    <= 16'h0000;
         fv_q       <= 1'b0;
         vc_q       <= 1'b0;
         se_q       <= 1'b0;
         qe_q       <= 1'b0;
         tmo_q      <= '0;
         stalled_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         next_idx_q <= next_idx_d;
         nib_q      <= nib_d;
         value_q    <= value_d;
         fv_q       <= fv_d;
         vc_q       <= vc_d;
         se_q       <= se_d;
         qe_q       <= qe_d;
         tmo_q      <= tmo_d;
         stalled_q  <= (tmo_d == TMO);
      end
   end

   assign value         = value_q;
   assign frame_valid   = fv_q;
   assign value_changed = vc_q;
   assign seg_err       = se_q;
   assign seq_err       = qe_q;
   assign stalled       = stalled_q;

endmodule
